// File: rtl/apb_master.sv
// Bridge from the core's single-request bus port to a four-window APB fabric (IDLE/SETUP/ACCESS).
// Optional macro APB_TIMEOUT_EN forces completion with 32'hDEAD_BEEF after TIMEOUT_CYCLES ACCESS cycles.
module apb_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transfer,
  input  logic [31:0] busAddr,
  input  logic        busWe,
  input  logic [31:0] busWData,
  input  logic [2:0]  strb,
  output logic [31:0] busRData,
  output logic        ready,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [3:0]  PSTRB,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [3:0]  PREADY
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  hit;
  logic [1:0]  hit_idx;
  logic [3:0]  psel_reg;
  logic [1:0]  sel_reg;
  logic [31:0] paddr_reg;
  logic [31:0] pwdata_reg;
  logic        pwrite_reg;
  logic [3:0]  pstrb_reg;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [31:0] prdata_arr [4];
  logic        accept;
  logic        mapped;
  logic        slave_ready;
  logic        timeout;

  // Window compare wraps in the 20-bit page number, so it is a plain equality per window.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      assign hit[gi] = (busAddr[31:12] == BASE_ADDR[31:12] + 20'(gi));
    end
  endgenerate

  always_comb begin
    hit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (hit[i]) hit_idx = 2'(i);
    end
  end

  always_comb begin
    lane_strb = 4'b0000;
    lane_data = busWData;
    case (strb[1:0])
      2'b00: begin
        lane_strb = 4'b0001 << busAddr[1:0];
        lane_data = {4{busWData[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << {busAddr[1], 1'b0};
        lane_data = {2{busWData[15:0]}};
      end
      default: lane_strb = 4'b1111;
    endcase
    if (!busWe) lane_strb = 4'b0000;
  end

  assign prdata_arr[0] = PRDATA0;
  assign prdata_arr[1] = PRDATA1;
  assign prdata_arr[2] = PRDATA2;
  assign prdata_arr[3] = PRDATA3;

  assign accept      = (state_reg == IDLE) && transfer;
  assign mapped      = |psel_reg;
  assign slave_ready = PREADY[sel_reg];

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] count_reg;
  logic          unused_strb;

  assign unused_strb = strb[2];
  assign timeout     = mapped && !slave_ready && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      count_reg <= '0;
    end else if (state_reg == ACCESS) begin
      if (ready)                     count_reg <= '0;
      else if (mapped && !slave_ready) count_reg <= count_reg + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = strb[2] ^ (TIMEOUT_CYCLES > 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busRData   = 32'h0;
    case (state_reg)
      IDLE:  if (transfer) state_next = SETUP;
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // Unmapped requests have no slave to wait on and return zero data.
        if (!mapped) begin
          ready = 1'b1;
        end else begin
          busRData = prdata_arr[sel_reg];
          if (slave_ready) begin
            ready = 1'b1;
          end else if (timeout) begin
            ready    = 1'b1;
            busRData = 32'hDEAD_BEEF;
          end
        end
        if (ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      psel_reg   <= 4'b0000;
      sel_reg    <= 2'd0;
      paddr_reg  <= 32'h0;
      pwdata_reg <= 32'h0;
      pwrite_reg <= 1'b0;
      pstrb_reg  <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        psel_reg   <= hit;
        sel_reg    <= hit_idx;
        paddr_reg  <= busAddr;
        pwdata_reg <= lane_data;
        pwrite_reg <= busWe;
        pstrb_reg  <= lane_strb;
      end
    end
  end

  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;
  assign PWRITE  = pwrite_reg;
  assign PSTRB   = pstrb_reg;
  assign PENABLE = (state_reg == ACCESS);
  assign PSEL    = (state_reg == IDLE) ? 4'b0000 : psel_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed and random APB transfers checked against an arithmetic model of windows, lanes and latency.
module tb_apb_master;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        transfer;
  logic [31:0] busAddr;
  logic        busWe;
  logic [31:0] busWData;
  logic [2:0]  strb;
  logic [31:0] busRData;
  logic        ready;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic [3:0]  PREADY;

  int checks   = 0;
  int failures = 0;

  apb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busAddr(busAddr), .busWe(busWe),
    .busWData(busWData), .strb(strb), .busRData(busRData), .ready(ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PRDATA3(PRDATA3), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window number by address arithmetic; -1 means unmapped.
  function automatic int win_of(input logic [31:0] addr);
    if (addr >= BASE && addr < BASE + 32'h4000) return int'((addr - BASE) / 32'h1000);
    return -1;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] addr, input logic [1:0] sz, input logic we);
    if (!we) return 4'd0;
    if (sz == 2'd0) return 4'(1 << (addr % 4));
    if (sz == 2'd1) return 4'(3 << (addr & 32'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit times_out(input int k);
`ifdef APB_TIMEOUT_EN
    return k == TO - 1;
`else
    return (k < 0);
`endif
  endfunction

  task automatic idle_check();
    @(negedge clk);
    transfer = 1'b0;
    #2;
    check("idle_psel", 32'(PSEL), 32'd0);
    check("idle_penable", 32'(PENABLE), 32'd0);
    check("idle_ready", 32'(ready), 32'd0);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input logic [2:0] sz, input int waits);
    int          w;
    int          k;
    bit          done;
    logic [31:0] pr [4];
    logic [31:0] edata;
    logic [3:0]  epsel;
    w     = win_of(addr);
    epsel = (w >= 0) ? 4'(1 << w) : 4'd0;
    for (int i = 0; i < 4; i++) pr[i] = $urandom;
    // T0: request while IDLE (also the release cycle of any previous transfer)
    @(negedge clk);
    transfer = 1'b1; busAddr = addr; busWe = we; busWData = wd; strb = sz;
    PRDATA0 = pr[0]; PRDATA1 = pr[1]; PRDATA2 = pr[2]; PRDATA3 = pr[3];
    PREADY = 4'($urandom);
    #2;
    check("t0_psel", 32'(PSEL), 32'd0);
    check("t0_penable", 32'(PENABLE), 32'd0);
    check("t0_ready", 32'(ready), 32'd0);
    // T1: SETUP
    @(negedge clk);
    transfer = 1'b0;
    #2;
    check("setup_psel", 32'(PSEL), 32'(epsel));
    check("setup_penable", 32'(PENABLE), 32'd0);
    check("setup_ready", 32'(ready), 32'd0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", 32'(PWRITE), 32'(we));
    check("setup_pstrb", 32'(PSTRB), 32'(exp_strb(addr, sz[1:0], we)));
    if (we) check("setup_pwdata", PWDATA, exp_wdata(wd, sz[1:0]));
    // ACCESS cycles until the model says the transfer completes
    k    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      PREADY = 4'($urandom);
      if (w >= 0) PREADY[w] = (k >= waits);
      done = (w < 0) || (k >= waits) || times_out(k);
      #2;
      check("acc_penable", 32'(PENABLE), 32'd1);
      check("acc_psel", 32'(PSEL), 32'(epsel));
      check("acc_paddr", PADDR, addr);
      check("acc_ready", 32'(ready), 32'(done));
      if (done) begin
        if (w < 0)           edata = 32'h0;
        else if (k >= waits) edata = pr[w];
        else                 edata = 32'hDEAD_BEEF;
        check("acc_rdata", busRData, edata);
      end
      k++;
    end
    $display("txn addr=%h we=%0d size=%0d win=%0d waits=%0d access_cycles=%0d", addr, we, sz, w, waits, k);
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    reset = 1'b1; transfer = 1'b0; busAddr = 32'h0; busWe = 1'b0; busWData = 32'h0; strb = 3'b010;
    PRDATA0 = 32'h0; PRDATA1 = 32'h0; PRDATA2 = 32'h0; PRDATA3 = 32'h0; PREADY = 4'hF;
    repeat (2) @(negedge clk);
    #2;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_pstrb", 32'(PSTRB), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", busRData, 32'd0);
    reset = 1'b0;

    run_txn(32'h1000_0004, 1'b1, 32'h1234_5678, 3'b010, 0);
    run_txn(32'h1000_1003, 1'b1, 32'h0000_00AB, 3'b000, 0);
    run_txn(32'h1000_2008, 1'b0, 32'h0,         3'b010, 3);
    run_txn(32'h2000_0000, 1'b0, 32'h0,         3'b010, 0);
    run_txn(32'h1000_3FFE, 1'b1, 32'h0000_BEEF, 3'b101, 1);
    run_txn(32'h0FFF_FFFF, 1'b1, 32'h5555_AAAA, 3'b010, 0);
    run_txn(32'h1000_4000, 1'b0, 32'h0,         3'b010, 0);
    run_txn(32'h1000_2001, 1'b1, 32'hFFFF_1234, 3'b001, 2);
    run_txn(32'h1000_0000, 1'b0, 32'h0,         3'b100, 20);
    idle_check();

    // Reset during a stalled ACCESS abandons the transfer
    @(negedge clk);
    transfer = 1'b1; busAddr = 32'h1000_1010; busWe = 1'b1; busWData = 32'hA5A5_5A5A; strb = 3'b010;
    PREADY = 4'b0000;
    @(negedge clk);
    transfer = 1'b0;
    @(negedge clk);
    #2;
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    check("pre_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rst_cycle_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("mid_rst_psel", 32'(PSEL), 32'd0);
    check("mid_rst_penable", 32'(PENABLE), 32'd0);
    check("mid_rst_paddr", PADDR, 32'd0);
    check("mid_rst_pwdata", PWDATA, 32'd0);
    check("mid_rst_pstrb", 32'(PSTRB), 32'd0);
    check("mid_rst_pwrite", 32'(PWRITE), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_rdata", busRData, 32'd0);
    run_txn(32'h1000_1010, 1'b1, 32'hA5A5_5A5A, 3'b010, 0);

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 4));
      if (r < 4) a = BASE + 32'(r) * 32'h1000 + 32'($urandom_range(0, 4095));
      else       a = 32'h3000_0000 + 32'($urandom_range(0, 65535));
      run_txn(a, 1'($urandom), $urandom, 3'($urandom_range(0, 2)) | {1'($urandom), 2'b00},
              int'($urandom_range(0, 3)));
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
